iobuf_bus_ctrl: RTL and testbench

//  Half-duplex controller for a tri-stated pad vector built from IobufVec. Drives the

---
 rtl/iobuf_bus_pkg.sv | 24 ++
 rtl/iobuf_bus_ctrl.sv | 130 +++++++++++++
 tb/tb_iobuf_bus_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/iobuf_bus_pkg.sv
// Shared types for the tri-state pad bus controller.
// FSM states, bus direction and counter sizing.
package iobuf_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    DRIVE,
    SAMPLE,
    RESP
  } IobufBusState;

  typedef enum logic {
    RELEASED,
    DRIVING
  } IobufDir;

  function automatic int cntWidth(int turn, int hold);
    int m;
    m = (turn > hold) ? turn : hold;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/iobuf_bus_ctrl.sv
// Half-duplex pad controller: drives IobufVec I/T, samples O,
// and inserts released turnaround cycles on every direction change.
module iobuf_bus_ctrl #(
  parameter int iovecWidth  = 8,
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [iovecWidth-1:0] reqData,
  output logic                  rspValid,
  input  logic                  rspReady,
  output logic [iovecWidth-1:0] rspData,
  output logic [iovecWidth-1:0] pinI,
  output logic                  pinT,
  input  logic [iovecWidth-1:0] pinO,
  output logic                  busy
);
  import iobuf_bus_pkg::*;

  localparam int CW = cntWidth(TURN_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  IobufBusState state, state_n;
  IobufDir      dir, dir_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          write, write_n;
  logic [iovecWidth-1:0] data, data_n;
  logic [iovecWidth-1:0] pin_i_n, rsp_data_n;
  logic          pin_t_n, rsp_valid_n;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      dir      <= RELEASED;
      cnt      <= '0;
      write    <= 1'b0;
      data     <= '0;
      pinI     <= '0;
      pinT     <= 1'b1;
      rspValid <= 1'b0;
      rspData  <= '0;
      reqReady <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      cnt      <= cnt_n;
      write    <= write_n;
      data     <= data_n;
      pinI     <= pin_i_n;
      pinT     <= pin_t_n;
      rspValid <= rsp_valid_n;
      rspData  <= rsp_data_n;
      reqReady <= (state_n == IDLE) && !rsp_valid_n;
      busy     <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n     = state;
    dir_n       = dir;
    cnt_n       = cnt;
    write_n     = write;
    data_n      = data;
    pin_i_n     = pinI;
    pin_t_n     = pinT;
    rsp_valid_n = rspValid;
    rsp_data_n  = rspData;
    unique case (state)
      IDLE: begin
        if (reqValid && reqReady) begin
          write_n = reqWrite;
          data_n  = reqData;
          if (reqWrite ? (dir == RELEASED) : (dir == DRIVING)) begin
            state_n = TURN;
            cnt_n   = TURN_LOAD;
            pin_t_n = 1'b1;
          end else if (reqWrite) begin
            state_n = DRIVE;
            cnt_n   = HOLD_LOAD;
            pin_t_n = 1'b0;
            pin_i_n = reqData;
          end else begin
            state_n = SAMPLE;
          end
        end
      end
      TURN: begin
        pin_t_n = 1'b1;
        if (cnt == '0) begin
          if (write) begin
            state_n = DRIVE;
            dir_n   = DRIVING;
            cnt_n   = HOLD_LOAD;
            pin_t_n = 1'b0;
            pin_i_n = data;
          end else begin
            state_n = SAMPLE;
            dir_n   = RELEASED;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DRIVE: begin
        // pads stay parked driving after the hold expires
        if (cnt == '0) state_n = IDLE;
        else cnt_n = cnt - CW'(1);
      end
      SAMPLE: begin
        rsp_data_n  = pinO;
        rsp_valid_n = 1'b1;
        state_n     = RESP;
      end
      RESP: begin
        if (rspReady) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iobuf_bus_ctrl.sv
// Randomized bench for iobuf_bus_ctrl against a
// transaction-level model of pad direction and latency.
module tb_iobuf_bus_ctrl;
  localparam int W  = 8;
  localparam int TC = 2;
  localparam int HC = 1;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic reqValid = 1'b0;
  logic reqWrite = 1'b0;
  logic rspReady = 1'b0;
  logic [W-1:0] reqData = '0;
  logic [W-1:0] pinO = '0;
  logic reqReady, rspValid, pinT, busy;
  logic [W-1:0] rspData, pinI;

  int n_chk = 0;
  int n_pass = 0;
  bit driving = 1'b0;
  logic [W-1:0] last_i = '0;

  iobuf_bus_ctrl #(
    .iovecWidth(W), .TURN_CYCLES(TC), .HOLD_CYCLES(HC)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqData(reqData),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspData(rspData),
    .pinI(pinI), .pinT(pinT), .pinO(pinO),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!reqReady && n < 20) begin
      step();
      n++;
    end
    chk("ready", 32'(reqReady), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_t", 32'(pinT), 32'(!driving));
      chk("idle_rdy", 32'(reqReady), 1);
      step();
    end
  endtask

  task automatic do_req(input bit wr, input logic [W-1:0] d,
                        input logic [W-1:0] pad, input int stall);
    bit turn;
    wait_ready();
    reqValid = 1'b1;
    reqWrite = wr;
    reqData  = d;
    pinO     = ~pad;
    step();
    reqValid = 1'b0;
    reqData  = W'($urandom);
    turn = wr ? !driving : driving;
    if (turn) begin
      for (int i = 0; i < TC; i++) begin
        chk("turn_t", 32'(pinT), 1);
        chk("turn_i", 32'(pinI), 32'(last_i));
        chk("turn_busy", 32'(busy), 1);
        step();
      end
    end
    if (wr) begin
      driving = 1'b1;
      last_i  = d;
      for (int i = 0; i < HC; i++) begin
        chk("drv_t", 32'(pinT), 0);
        chk("drv_i", 32'(pinI), 32'(d));
        chk("drv_rdy", 32'(reqReady), 0);
        step();
      end
      chk("park_t", 32'(pinT), 0);
      chk("park_i", 32'(pinI), 32'(d));
      chk("wr_idle_busy", 32'(busy), 0);
      chk("wr_idle_rdy", 32'(reqReady), 1);
    end else begin
      driving = 1'b0;
      pinO = pad;
      chk("smp_t", 32'(pinT), 1);
      chk("smp_v", 32'(rspValid), 0);
      step();
      pinO = ~pad;
      reqValid = 1'b1;
      reqWrite = 1'b1;
      for (int k = 0; k < stall; k++) begin
        chk("rsp_v", 32'(rspValid), 1);
        chk("rsp_d", 32'(rspData), 32'(pad));
        chk("rsp_rdy", 32'(reqReady), 0);
        chk("rsp_t", 32'(pinT), 1);
        step();
      end
      reqValid = 1'b0;
      rspReady = 1'b1;
      chk("hs_v", 32'(rspValid), 1);
      chk("hs_d", 32'(rspData), 32'(pad));
      step();
      rspReady = 1'b0;
      chk("done_v", 32'(rspValid), 0);
      chk("done_rdy", 32'(reqReady), 1);
      chk("done_t", 32'(pinT), 1);
      chk("done_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    #12;
    chk("rst_t", 32'(pinT), 1);
    chk("rst_i", 32'(pinI), 0);
    chk("rst_v", 32'(rspValid), 0);
    chk("rst_d", 32'(rspData), 0);
    chk("rst_rdy", 32'(reqReady), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge CLK);
    nRST = 1'b1;
    step();
    chk("rel_rdy", 32'(reqReady), 1);

    do_req(1'b1, 8'hA5, 8'h00, 0);
    do_req(1'b0, 8'h00, 8'h3C, 0);
    do_req(1'b0, 8'h00, 8'h11, 0);
    do_req(1'b0, 8'h00, 8'h22, 0);
    do_req(1'b0, 8'h00, 8'h5A, 5);
    do_req(1'b1, 8'h01, 8'h00, 0);
    do_req(1'b1, 8'h02, 8'h00, 0);
    do_req(1'b0, 8'h00, 8'h77, 1);
    do_req(1'b1, 8'h03, 8'h00, 0);

    repeat (60) begin
      idle($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), W'($urandom),
             W'($urandom), $urandom_range(0, 4));
    end

    // reset in the middle of a turned write's drive phase
    do_req(1'b0, 8'h00, 8'h44, 0);
    wait_ready();
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqData  = 8'hC3;
    step();
    reqValid = 1'b0;
    for (int i = 0; i < TC; i++) step();
    chk("mid_drv_t", 32'(pinT), 0);
    chk("mid_drv_i", 32'(pinI), 32'(8'hC3));
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_t", 32'(pinT), 1);
    chk("arst_i", 32'(pinI), 0);
    chk("arst_v", 32'(rspValid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rdy", 32'(reqReady), 0);
    driving = 1'b0;
    last_i  = '0;
    @(negedge CLK);
    nRST = 1'b1;
    step();
    chk("arel_rdy", 32'(reqReady), 1);
    chk("arel_v", 32'(rspValid), 0);
    do_req(1'b1, 8'h96, 8'h00, 0);
    do_req(1'b0, 8'h00, 8'hE1, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
